cpu_mem_arbiter: RTL and testbench
==================================

// Module: cpu_mem_arbiter
// PURPOSE
//  Shares the single-port 16x8 CPU RAM between the SAP-1 CPU and a programmer/debug port.
//  The arbiter asks the CPU to stall at an instruction boundary, grants the RAM to the
//  programmer for a bounded burst, then returns it. It sits between the CPU control,
//  the programmer front end and cpu_mem. RAM latches addr/write on negedge clk.
//  Read data is valid at the following posedge.
// PARAMETERS
//  ADDR_W       4   RAM address width
//  DATA_W       8   RAM data width
//  MAX_BURST    8   max programmer accesses per grant; 0 = unlimited
//  COOL_CYCLES  2   min CPU-owned cycles after a grant ends (>=1)
// PORTS
//  clk            in   1       system clock, rising-edge logic
//  rst            in   1       synchronous, active-high reset
//  cpu_we_i       in   1       CPU write enable
//  cpu_addr_i     in   ADDR_W  CPU address
//  cpu_data_i     in   DATA_W  CPU write data
//  cpu_idle_i     in   1       CPU parked at instruction boundary (held while stalled)
//  cpu_stall_o    out  1       request CPU to stop at next boundary and stay stopped
//  prog_req_i     in   1       programmer wants the RAM (level, held for whole burst)
//  prog_gnt_o     out  1       programmer owns RAM this cycle
//  prog_valid_i   in   1       programmer access this cycle (counted only while gnt=1)
//  prog_we_i      in   1       1 = write, 0 = read
//  prog_addr_i    in   ADDR_W  programmer address
//  prog_data_i    in   DATA_W  programmer write data
//  prog_rdata_o   out  DATA_W  read data; meaningful only when prog_rvalid_o=1
//  prog_rvalid_o  out  1       read data valid, one cycle after accepted read
//  mem_we_o       out  1       to cpu_mem we_i
//  mem_addr_o     out  ADDR_W  to cpu_mem addr_i
//  mem_data_o     out  DATA_W  to cpu_mem data_in_i
//  mem_data_i     in   DATA_W  from cpu_mem data_out_o
// BEHAVIOUR
//  States: CPU, DRAIN, PROG, COOL. Reset -> CPU. Counters clear. stall=0, gnt=0, rvalid=0.
//  - CPU: RAM mux = CPU. prog_req_i=1 -> DRAIN.
//  - DRAIN: stall=1, mux = CPU (CPU finishing its instruction). prog_req_i=0 -> CPU.
//    Else cpu_idle_i=1 -> PROG. No timeout; waits indefinitely for idle.
//  - PROG: gnt=1, stall=1, mux = programmer.
//    An access is accepted when prog_valid_i=1. Accepted access increments burst_cnt.
//    mem_we_o = prog_valid_i & prog_we_i. The CPU write path is fully blocked.
//    -> COOL when prog_req_i=0, or on the accepted access with burst_cnt==MAX_BURST-1
//       (if MAX_BURST!=0). That access still completes.
//  - COOL: gnt=0, stall=0, mux = CPU. Hold COOL_CYCLES cycles -> CPU.
//    A still-held req then re-enters DRAIN. This guarantees CPU forward progress.
//  - All outputs except prog_rdata_o are registered or decoded from state only.
//    The mem_* mux is combinational from the state register plus the selected inputs.
//  - prog_rvalid_o <= (state==PROG & prog_valid_i & ~prog_we_i).
//    prog_rdata_o = mem_data_i (pass-through).
//    A read accepted on the last grant cycle still yields rvalid in the next (COOL) cycle.
//  - Write at addr A in cycle N, then read A in N+1 -> returns the new data (negedge ordering).
//  - burst_cnt clears on entry to PROG. Width = clog2(MAX_BURST+1), no wrap in unlimited mode.
//  - COOL counter clears on entry to COOL.
//  - rst in any state -> next cycle CPU. Pending rvalid is dropped. Burst in progress is
//    abandoned; writes already issued persist.
//  - prog_req_i rising and falling in the same DRAIN cycle as cpu_idle_i: req=0 wins -> CPU.
// STRUCTURE
//  - arb_state_t (CPU, DRAIN, PROG, COOL) is an enum in cpu_package.svh, shared with the debug display.
//  - Single module with one state always_ff, burst/cool counters and a combinational mem mux.
//  - No sub-module is warranted.
// TESTING
//  1. After rst, CPU write addr 3 = 0x5A -> mem_we_o=1, mem_addr_o=3, mem_data_o=0x5A; stall=0, gnt=0.
//  2. prog_req_i=1, cpu_idle_i low for 5 cycles -> stall=1, gnt=0 throughout.
//     Idle rises -> gnt=1 next cycle.
//  3. In PROG: write addr 7 = 0xAB, next cycle read addr 7 -> rvalid=1 the following cycle
//     with rdata=0xAB.
//  4. MAX_BURST=4, 6 back-to-back accesses -> gnt drops after 4th, stall=0 for 2 COOL cycles,
//     re-DRAIN, regrant, remaining 2 complete.
//  5. rst during PROG with a read in flight -> next cycle gnt=0, rvalid=0, stall=0, state CPU.
//  6. prog_req_i dropped in DRAIN before idle -> next cycle state CPU, stall=0, RAM never granted.

Source files
------------

// File: rtl/cpu_mem_arbiter_pkg.sv
// Shared definitions for the CPU/programmer RAM arbiter: state encodings and
// the arbiter state type used by the debug display.
package cpu_mem_arbiter_pkg;

  localparam logic [1:0] ST_CPU   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_PROG  = 2'd2;
  localparam logic [1:0] ST_COOL  = 2'd3;

  typedef enum logic [1:0] {
    ARB_CPU   = 2'd0,
    ARB_DRAIN = 2'd1,
    ARB_PROG  = 2'd2,
    ARB_COOL  = 2'd3
  } arb_state_t;

  // Counter width able to hold max_val; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/cpu_mem_arbiter.sv
// Arbitrates the single-port CPU RAM between the SAP-1 core and the programmer port:
// stall the CPU at a boundary, grant a bounded burst, then force a CPU-owned cool-down.
module cpu_mem_arbiter
  import cpu_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int MAX_BURST   = 8,
  parameter int COOL_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_data_i,
  input  logic              cpu_idle_i,
  output logic              cpu_stall_o,
  input  logic              prog_req_i,
  output logic              prog_gnt_o,
  input  logic              prog_valid_i,
  input  logic              prog_we_i,
  input  logic [ADDR_W-1:0] prog_addr_i,
  input  logic [DATA_W-1:0] prog_data_i,
  output logic [DATA_W-1:0] prog_rdata_o,
  output logic              prog_rvalid_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i
);

  localparam int BURST_W = cnt_width(MAX_BURST);
  localparam int COOL_W  = cnt_width(COOL_CYCLES);
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
  localparam logic [COOL_W-1:0]  COOL_LAST  = COOL_W'(COOL_CYCLES - 1);
  localparam bit LIMITED = (MAX_BURST != 0);

  logic [1:0]         state_q;
  logic [1:0]         state_d;
  logic [BURST_W-1:0] burst_cnt;
  logic [COOL_W-1:0]  cool_cnt;
  logic               prog_vld_p1;
  logic               accept;
  logic               last_acc;

  assign accept   = (state_q == ST_PROG) && prog_valid_i;
  assign last_acc = LIMITED && accept && (burst_cnt == BURST_LAST);

  // Dropping the request always wins over idle, so a programmer that gives up
  // mid-drain never gets a stray grant.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CPU:   if (prog_req_i) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!prog_req_i)     state_d = ST_CPU;
        else if (cpu_idle_i) state_d = ST_PROG;
      end
      ST_PROG:  if (!prog_req_i || last_acc) state_d = ST_COOL;
      default:  if (cool_cnt == COOL_LAST) state_d = ST_CPU;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_CPU;
      burst_cnt   <= '0;
      cool_cnt    <= '0;
      prog_vld_p1 <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q != ST_PROG && state_d == ST_PROG)
        burst_cnt <= '0;
      else if (accept && (LIMITED || burst_cnt != '1))
        burst_cnt <= burst_cnt + BURST_W'(1);
      if (state_q != ST_COOL && state_d == ST_COOL)
        cool_cnt <= '0;
      else if (state_q == ST_COOL)
        cool_cnt <= cool_cnt + COOL_W'(1);
      // p0 -> p1: read accepted this cycle, RAM data lands next cycle
      prog_vld_p1 <= accept && !prog_we_i;
    end
  end

  assign cpu_stall_o   = (state_q == ST_DRAIN) || (state_q == ST_PROG);
  assign prog_gnt_o    = (state_q == ST_PROG);
  assign prog_rvalid_o = prog_vld_p1;
  assign prog_rdata_o  = mem_data_i;

  always_comb begin
    if (state_q == ST_PROG) begin
      mem_we_o   = prog_valid_i && prog_we_i;
      mem_addr_o = prog_addr_i;
      mem_data_o = prog_data_i;
    end else begin
      mem_we_o   = cpu_we_i;
      mem_addr_o = cpu_addr_i;
      mem_data_o = cpu_data_i;
    end
  end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed table-driven bench for cpu_mem_arbiter with a negedge-latching 16x8 RAM model.
module tb_cpu_mem_arbiter;

  logic       clk;
  logic       rst;
  logic       cpu_we_i;
  logic [3:0] cpu_addr_i;
  logic [7:0] cpu_data_i;
  logic       cpu_idle_i;
  logic       cpu_stall_o;
  logic       prog_req_i;
  logic       prog_gnt_o;
  logic       prog_valid_i;
  logic       prog_we_i;
  logic [3:0] prog_addr_i;
  logic [7:0] prog_data_i;
  logic [7:0] prog_rdata_o;
  logic       prog_rvalid_o;
  logic       mem_we_o;
  logic [3:0] mem_addr_o;
  logic [7:0] mem_data_o;
  logic [7:0] mem_data_i;

  cpu_mem_arbiter #(
    .ADDR_W(4), .DATA_W(8), .MAX_BURST(4), .COOL_CYCLES(2)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
    .cpu_idle_i(cpu_idle_i), .cpu_stall_o(cpu_stall_o),
    .prog_req_i(prog_req_i), .prog_gnt_o(prog_gnt_o),
    .prog_valid_i(prog_valid_i), .prog_we_i(prog_we_i),
    .prog_addr_i(prog_addr_i), .prog_data_i(prog_data_i),
    .prog_rdata_o(prog_rdata_o), .prog_rvalid_o(prog_rvalid_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_data_i(mem_data_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM model: latches address/write on the falling edge, data visible at next rise.
  logic [7:0] ram [16];
  logic [7:0] ram_q;
  initial begin
    for (int i = 0; i < 16; i++) ram[i] = 8'h00;
    ram_q = 8'h00;
  end
  always @(negedge clk) begin
    if (mem_we_o) ram[mem_addr_o] <= mem_data_o;
    ram_q <= ram[mem_addr_o];
  end
  assign mem_data_i = ram_q;

  typedef struct {
    logic       rst;
    logic       cwe;
    logic [3:0] ca;
    logic [7:0] cd;
    logic       idle;
    logic       req;
    logic       pv;
    logic       pwe;
    logic [3:0] pa;
    logic [7:0] pd;
    logic       e_stall;
    logic       e_gnt;
    logic       e_rv;
    logic       e_mwe;
    logic [3:0] e_ma;
    logic [7:0] e_md;
    logic       chk_rd;
    logic [7:0] e_rd;
  } vec_t;

  vec_t vecs[$];
  int   n_vec;
  int   n_bad;

  function automatic vec_t mk(
    input logic r, input logic cwe, input logic [3:0] ca, input logic [7:0] cd,
    input logic idle, input logic req, input logic pv, input logic pwe,
    input logic [3:0] pa, input logic [7:0] pd,
    input logic st, input logic gn, input logic rv, input logic mwe,
    input logic [3:0] ma, input logic [7:0] md, input logic crd, input logic [7:0] rd);
    vec_t v;
    v.rst = r; v.cwe = cwe; v.ca = ca; v.cd = cd; v.idle = idle; v.req = req;
    v.pv = pv; v.pwe = pwe; v.pa = pa; v.pd = pd;
    v.e_stall = st; v.e_gnt = gn; v.e_rv = rv; v.e_mwe = mwe;
    v.e_ma = ma; v.e_md = md; v.chk_rd = crd; v.e_rd = rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; cpu_we_i = v.cwe; cpu_addr_i = v.ca; cpu_data_i = v.cd;
    cpu_idle_i = v.idle; prog_req_i = v.req; prog_valid_i = v.pv;
    prog_we_i = v.pwe; prog_addr_i = v.pa; prog_data_i = v.pd;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    // CPU write, then programmer request held while CPU is busy
    vecs.push_back(mk(0,1,3,8'h5A,0,0,0,0,0,0,     0,0,0,1,3,8'h5A,0,0));
    vecs.push_back(mk(0,0,1,0,0,1,0,0,0,0,         0,0,0,0,1,0,0,0));
    vecs.push_back(mk(0,1,2,8'h11,0,1,0,0,0,0,     1,0,0,1,2,8'h11,0,0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0,0,0,0,0,1,0,0,0,0,       1,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,1,1,0,0,0,0,         1,0,0,0,0,0,0,0));
    // Granted: write 7, read back 7; concurrent CPU write must be blocked
    vecs.push_back(mk(0,1,3,8'hFF,1,1,1,1,7,8'hAB, 1,1,0,1,7,8'hAB,0,0));
    vecs.push_back(mk(0,0,0,0,1,1,1,0,7,0,         1,1,0,0,7,0,0,0));
    vecs.push_back(mk(0,0,0,0,1,1,0,0,0,0,         1,1,1,0,0,0,1,8'hAB));
    vecs.push_back(mk(0,0,0,0,1,0,0,0,0,0,         1,1,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,5,8'h22,0,0,0,0,0,0,     0,0,0,0,5,8'h22,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,         0,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,         0,0,0,0,0,0,0,0));
    // Burst limit of 4 with 6 back-to-back accesses
    vecs.push_back(mk(0,0,0,0,0,1,0,0,0,0,         0,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,1,1,0,0,0,0,         1,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,1,1,1,1,8,8'h80,     1,1,0,1,8,8'h80,0,0));
    vecs.push_back(mk(0,0,0,0,1,1,1,1,9,8'h81,     1,1,0,1,9,8'h81,0,0));
    vecs.push_back(mk(0,0,0,0,1,1,1,0,3,0,         1,1,0,0,3,0,0,0));
    vecs.push_back(mk(0,0,0,0,1,1,1,1,10,8'h82,    1,1,1,1,10,8'h82,1,8'h5A));
    vecs.push_back(mk(0,0,0,0,1,1,1,1,11,8'h83,    0,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,1,1,1,1,11,8'h83,    0,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,1,1,1,1,11,8'h83,    0,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,1,1,1,1,11,8'h83,    1,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,1,1,1,1,11,8'h83,    1,1,0,1,11,8'h83,0,0));
    vecs.push_back(mk(0,0,0,0,1,1,1,0,9,0,         1,1,0,0,9,0,0,0));
    vecs.push_back(mk(0,0,0,0,1,0,0,0,0,0,         1,1,1,0,0,0,1,8'h81));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,         0,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,         0,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,         0,0,0,0,0,0,0,0));
    // Request withdrawn in DRAIN in the same cycle idle rises
    vecs.push_back(mk(0,0,0,0,0,1,0,0,0,0,         0,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,1,0,0,0,0,         1,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,1,0,0,0,0,0,         1,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,1,0,0,0,0,0,         0,0,0,0,0,0,0,0));
    // Reset in PROG with a read in flight
    vecs.push_back(mk(0,0,0,0,0,1,0,0,0,0,         0,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,1,1,0,0,0,0,         1,0,0,0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,1,1,1,0,8,0,         1,1,0,0,8,0,0,0));
    vecs.push_back(mk(0,0,0,0,1,1,0,0,0,0,         0,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,1,0,0,0,0,0,         1,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,         0,0,0,0,0,0,0,0));

    rst = 1'b1; cpu_we_i = 0; cpu_addr_i = 0; cpu_data_i = 0; cpu_idle_i = 0;
    prog_req_i = 0; prog_valid_i = 0; prog_we_i = 0; prog_addr_i = 0; prog_data_i = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("reset_stall", {31'd0, cpu_stall_o}, 32'd0);
    chk("reset_gnt", {31'd0, prog_gnt_o}, 32'd0);
    chk("reset_rvalid", {31'd0, prog_rvalid_o}, 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d_stall", i), {31'd0, cpu_stall_o}, {31'd0, vecs[i].e_stall});
      chk($sformatf("v%0d_gnt", i), {31'd0, prog_gnt_o}, {31'd0, vecs[i].e_gnt});
      chk($sformatf("v%0d_rvalid", i), {31'd0, prog_rvalid_o}, {31'd0, vecs[i].e_rv});
      chk($sformatf("v%0d_mem_we", i), {31'd0, mem_we_o}, {31'd0, vecs[i].e_mwe});
      chk($sformatf("v%0d_mem_addr", i), {28'd0, mem_addr_o}, {28'd0, vecs[i].e_ma});
      chk($sformatf("v%0d_mem_data", i), {24'd0, mem_data_o}, {24'd0, vecs[i].e_md});
      if (vecs[i].chk_rd)
        chk($sformatf("v%0d_rdata", i), {24'd0, prog_rdata_o}, {24'd0, vecs[i].e_rd});
      @(posedge clk); #1;
    end

    // Continuous streaming: grant length and forced CPU gap between grants
    begin
      int k;
      int run;
      int gap;
      rst = 0; cpu_we_i = 0; cpu_idle_i = 1; prog_req_i = 1;
      prog_valid_i = 1; prog_we_i = 1; prog_addr_i = 4'hC; prog_data_i = 8'h55;
      #1;
      k = 0;
      while (!prog_gnt_o && k < 10) begin
        @(posedge clk); #1; k++;
      end
      chk("hs_first_gnt", {31'd0, prog_gnt_o}, 32'd1);
      run = 0;
      while (prog_gnt_o && run < 20) begin
        @(posedge clk); #1; run++;
      end
      chk("hs_burst_len", run, 32'd4);
      chk("hs_cool_stall", {31'd0, cpu_stall_o}, 32'd0);
      gap = 0;
      while (!prog_gnt_o && gap < 20) begin
        @(posedge clk); #1; gap++;
      end
      chk("hs_gap_len", gap, 32'd4);
      chk("hs_regrant_stall", {31'd0, cpu_stall_o}, 32'd1);
      prog_req_i = 0; prog_valid_i = 0;
      @(posedge clk); #1;
      chk("hs_release_gnt", {31'd0, prog_gnt_o}, 32'd0);
      chk("hs_release_stall", {31'd0, cpu_stall_o}, 32'd0);
      chk("hs_ram_c", {24'd0, ram[12]}, 32'h55);
      chk("hs_ram_b", {24'd0, ram[11]}, 32'h83);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
